// File: rtl/pc_control_if.sv
// Fetch-path bundle between the CPU datapath (master) and the next-PC unit (slave).
// The master drives the decoded branch fields, flags and PC; the slave returns the next PC.
interface pc_control_if;
  logic [2:0]  C;
  logic [8:0]  I;
  logic [2:0]  F;
  logic        Branch;
  logic        BranchReg;
  logic [15:0] PC_in;
  logic [15:0] rs_in;
  logic [15:0] PC_out;

  modport master (
    output C, I, F, Branch, BranchReg, PC_in, rs_in,
    input  PC_out
  );

  modport slave (
    input  C, I, F, Branch, BranchReg, PC_in, rs_in,
    output PC_out
  );
endinterface

// File: rtl/pc_control.sv
// Next-PC selection (PC+2, PC-relative branch, register branch) and the PC register
// for the 16-bit single-cycle CPU fetch path.
module pc_control (
  input  logic          clk,
  input  logic          rst,
  pc_control_if.slave   bus
);

  logic        flag_z, flag_v, flag_n;
  logic        cond;
  logic [15:0] pc_plus2;
  logic [15:0] offset;
  logic [15:0] br_target;
  logic [15:0] pc_d, pc_q;

  assign flag_z = bus.F[2];
  assign flag_v = bus.F[1];
  assign flag_n = bus.F[0];

  assign pc_plus2  = bus.PC_in + 16'd2;
  assign offset    = {{6{bus.I[8]}}, bus.I, 1'b0};
  assign br_target = pc_plus2 + offset;

  // NOTE: every signal gets a value before the case/if, so no path can infer a latch.
  always_comb begin
    cond = 1'b0;
    unique case (bus.C)
      3'b000:  cond = ~flag_z;
      3'b001:  cond = flag_z;
      3'b010:  cond = ~flag_z & ~flag_n;
      3'b011:  cond = flag_n;
      3'b100:  cond = flag_z | ~flag_n;
      3'b101:  cond = flag_n | flag_z;
      3'b110:  cond = flag_v;
      default: cond = 1'b1;
    endcase
  end

  // The outer guard keeps unknown C/F/I/rs_in out of the PC when no branch is decoded.
  always_comb begin
    pc_d = pc_plus2;
    if (bus.Branch | bus.BranchReg) begin
      if (cond && bus.BranchReg)   pc_d = bus.rs_in;
      else if (cond && bus.Branch) pc_d = br_target;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 16'h0000;
    else     pc_q <= pc_d;
  end

  assign bus.PC_out = pc_q;

endmodule

// File: tb/tb_pc_control.sv
// Directed, table-driven bench for pc_control: vector table, condition sweep
// and hand-written reset sequences.
module tb_pc_control;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_control_if bus ();

  pc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  c;
    logic [8:0]  i;
    logic [2:0]  f;
    logic        branch;
    logic        branch_reg;
    logic [15:0] pc_in;
    logic [15:0] rs_in;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  // Bit f of each mask is the expected condition for flags value f = {Z,V,N}.
  logic [7:0] cond_mask [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.C         = v.c;
    bus.I         = v.i;
    bus.F         = v.f;
    bus.Branch    = v.branch;
    bus.BranchReg = v.branch_reg;
    bus.PC_in     = v.pc_in;
    bus.rs_in     = v.rs_in;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(v.name, bus.PC_out, v.exp_pc);
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] c, input logic [8:0] i,
                              input logic [2:0] f, input logic br, input logic brr,
                              input logic [15:0] pc, input logic [15:0] rs,
                              input logic [15:0] exp);
    vec_t v;
    v.name = name; v.c = c; v.i = i; v.f = f; v.branch = br; v.branch_reg = brr;
    v.pc_in = pc; v.rs_in = rs; v.exp_pc = exp;
    return v;
  endfunction

  initial begin
    vec_t v;

    cond_mask[0] = 8'h0F;  // NEQ
    cond_mask[1] = 8'hF0;  // EQ
    cond_mask[2] = 8'h05;  // GT
    cond_mask[3] = 8'hAA;  // LT
    cond_mask[4] = 8'hF5;  // GTE
    cond_mask[5] = 8'hFA;  // LTE
    cond_mask[6] = 8'hCC;  // OVF
    cond_mask[7] = 8'hFF;  // UNC

    vecs.push_back(mk("eq_taken",       3'b001, 9'h002, 3'b100, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0006));
    vecs.push_back(mk("eq_not_taken",   3'b001, 9'h002, 3'b000, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000));
    vecs.push_back(mk("neg_offset",     3'b111, 9'h1FF, 3'b000, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0010));
    vecs.push_back(mk("brreg_wins",     3'b111, 9'h004, 3'b000, 1'b1, 1'b1, 16'h0200, 16'h00FF, 16'h00FF));
    vecs.push_back(mk("brreg_not_tkn",  3'b110, 9'h004, 3'b000, 1'b1, 1'b1, 16'h1234, 16'h00FF, 16'h1236));
    vecs.push_back(mk("brreg_only",     3'b110, 9'h004, 3'b010, 1'b0, 1'b1, 16'h1234, 16'hABCD, 16'hABCD));
    vecs.push_back(mk("brreg_odd_rs",   3'b111, 9'h000, 3'b000, 1'b0, 1'b1, 16'h0000, 16'h8001, 16'h8001));
    vecs.push_back(mk("max_pos_offset", 3'b111, 9'h0FF, 3'b000, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h1200));
    vecs.push_back(mk("max_neg_offset", 3'b111, 9'h100, 3'b000, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0E02));
    vecs.push_back(mk("target_wrap",    3'b111, 9'h010, 3'b000, 1'b1, 1'b0, 16'hFFF0, 16'h0000, 16'h0012));
    vecs.push_back(mk("no_branch_x",    3'bxxx, 9'hxxx, 3'bxxx, 1'b0, 1'b0, 16'h0100, 16'hxxxx, 16'h0102));
    vecs.push_back(mk("no_branch_unc",  3'b111, 9'h020, 3'b000, 1'b0, 1'b0, 16'h0100, 16'h5555, 16'h0102));

    rst = 1'b1;
    drive(mk("idle", 3'b000, 9'h000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    #1;
    check("reset_initial", bus.PC_out, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold_edge", bus.PC_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        v = mk($sformatf("sweep_c%0d_f%0d", c, f), 3'(c), 9'h004, 3'(f), 1'b1, 1'b0,
               16'h0100, 16'hDEAD, cond_mask[c][f] ? 16'h010A : 16'h0102);
        apply(v);
      end
    end

    // Asynchronous reset arriving mid-cycle must clear the PC before the next edge.
    apply(mk("pre_reset", 3'b000, 9'h000, 3'b000, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0042));
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", bus.PC_out, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held", bus.PC_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", bus.PC_out, 16'h0000);
    @(posedge clk);
    #1;
    check("first_after_reset", bus.PC_out, 16'h0042);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
